// File: rtl/imm_pkg.sv
// Shared types for the decode-stage immediate generator.
package imm_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_J = 3'b010,
        IMM_Z = 3'b100,
        IMM_B = 3'b101,
        IMM_U = 3'b110
    } imm_src_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate extraction and extension from instruction bits [31:7].
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [24:0]     inst,
    input  logic [2:0]      immsrc,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    // inst[n] here is full-instruction bit n+7; every format is built at
    // 32 bits first and then sign-extended from bit 31 to XLEN.
    logic [31:0] v32;

    always_comb begin
        v32     = '0;
        illegal = 1'b0;
        case (imm_src_e'(immsrc))
            IMM_I:   v32 = {{20{inst[24]}}, inst[24:13]};
            IMM_S:   v32 = {{20{inst[24]}}, inst[24:18], inst[4:0]};
            IMM_B:   v32 = {{20{inst[24]}}, inst[0], inst[23:18], inst[4:1], 1'b0};
            IMM_J:   v32 = {{12{inst[24]}}, inst[12:5], inst[13], inst[23:14], 1'b0};
            IMM_U:   v32 = {inst[24:5], 12'b0};
            IMM_Z:   v32 = {27'b0, inst[12:8]};
            default: illegal = 1'b1;
        endcase
    end

    generate
        if (XLEN > 32) begin : g_wide
            assign imm = {{(XLEN-32){v32[31]}}, v32};
        end else begin : g_narrow
            assign imm = v32;
        end
    endgenerate

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator followed by an elastic valid/ready pipeline of STAGES registers.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int STAGES = 1,
    parameter int TAG_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [24:0]      in_inst,
    input  logic [2:0]       in_immsrc,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    logic [XLEN-1:0] dec_imm;
    logic            dec_ill;

    imm_decode #(.XLEN(XLEN)) u_dec (
        .inst    (in_inst),
        .immsrc  (in_immsrc),
        .imm     (dec_imm),
        .illegal (dec_ill)
    );

    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0]            ill_pipe;
    logic [STAGES-1:0][XLEN-1:0]  imm_pipe;
    logic [STAGES-1:0][TAG_W-1:0] tag_pipe;

    // rdy[k] is the load enable of stage k; rdy[STAGES] is the downstream ready.
    logic [STAGES:0] rdy;

    always_comb begin
        rdy         = '0;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--)
            rdy[k] = !vld_pipe[k] || rdy[k+1];
    end

    assign in_ready = rdy[0];

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            logic             v_in;
            logic             l_in;
            logic [XLEN-1:0]  i_in;
            logic [TAG_W-1:0] t_in;

            if (k == 0) begin : g_head
                assign v_in = in_valid;
                assign l_in = dec_ill;
                assign i_in = dec_imm;
                assign t_in = in_tag;
            end else begin : g_tail
                assign v_in = vld_pipe[k-1];
                assign l_in = ill_pipe[k-1];
                assign i_in = imm_pipe[k-1];
                assign t_in = tag_pipe[k-1];
            end

            // Data only moves with a real beat so an emptied stage keeps known values.
            always_ff @(posedge clk) begin
                if (reset) begin
                    vld_pipe[k] <= 1'b0;
                    ill_pipe[k] <= 1'b0;
                    imm_pipe[k] <= '0;
                    tag_pipe[k] <= '0;
                end else begin
                    if (rdy[k]) begin
                        vld_pipe[k] <= v_in;
                        if (v_in) begin
                            ill_pipe[k] <= l_in;
                            imm_pipe[k] <= i_in;
                            tag_pipe[k] <= t_in;
                        end
                    end
                    if (flush)
                        vld_pipe[k] <= 1'b0;
                end
            end
        end
    endgenerate

    assign out_valid   = vld_pipe[STAGES-1];
    assign out_illegal = ill_pipe[STAGES-1];
    assign out_imm     = imm_pipe[STAGES-1];
    assign out_tag     = tag_pipe[STAGES-1];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: latency table on three configurations, then random backpressure, flush and reset.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared stimulus for the 32-bit instances (STAGES=1 and STAGES=2)
    logic        a_valid, a_flush, a_oready;
    logic [24:0] a_inst;
    logic [2:0]  a_src;
    logic [7:0]  a_tag;
    logic        a1_ready, a1_valid, a1_ill, a2_ready, a2_valid, a2_ill;
    logic [31:0] a1_imm, a2_imm;
    logic [7:0]  a1_tag, a2_tag;

    // 64-bit, three-stage instance
    logic        b_valid, b_flush, b_oready;
    logic [24:0] b_inst;
    logic [2:0]  b_src;
    logic [7:0]  b_tag;
    logic        b_ready, b_ovalid, b_ill;
    logic [63:0] b_imm;
    logic [7:0]  b_otag;

    imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(8)) u_a1 (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a1_ready),
        .in_inst(a_inst), .in_immsrc(a_src), .in_tag(a_tag), .flush(a_flush),
        .out_valid(a1_valid), .out_ready(a_oready), .out_imm(a1_imm),
        .out_illegal(a1_ill), .out_tag(a1_tag));

    imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(8)) u_a2 (
        .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a2_ready),
        .in_inst(a_inst), .in_immsrc(a_src), .in_tag(a_tag), .flush(a_flush),
        .out_valid(a2_valid), .out_ready(a_oready), .out_imm(a2_imm),
        .out_illegal(a2_ill), .out_tag(a2_tag));

    imm_gen_pipe #(.XLEN(64), .STAGES(3), .TAG_W(8)) u_b (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_inst(b_inst), .in_immsrc(b_src), .in_tag(b_tag), .flush(b_flush),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_imm(b_imm),
        .out_illegal(b_ill), .out_tag(b_otag));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference: immediate rules from the ISA written as signed 64-bit arithmetic.
    // Returns {illegal, imm}.
    function automatic logic [64:0] ref_model(input logic [31:0] i, input logic [2:0] s);
        longint x, r;
        logic   il;
        x  = longint'($signed(i));
        r  = 0;
        il = 1'b0;
        case (s)
            3'd0: r = x >>> 20;
            3'd1: r = ((x >>> 25) <<< 5) | longint'(i[11:7]);
            3'd5: r = ((x >>> 31) <<< 12) | (longint'(i[7]) << 11)
                      | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
            3'd2: r = ((x >>> 31) <<< 20) | (longint'(i[19:12]) << 12)
                      | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
            3'd6: r = (x >>> 12) <<< 12;
            3'd4: r = longint'(i[19:15]);
            default: il = 1'b1;
        endcase
        return {il, r};
    endfunction

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  src;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [63:0] imm;
        logic        ill;
        logic [7:0]  tag;
    } beat_t;

    localparam int NV = 11;
    vec_t  tbl [NV];
    beat_t q [$];
    logic        stall_prev = 1'b0;
    logic [63:0] prev_imm;
    logic        prev_ill;
    logic [7:0]  prev_tag;

    // Inputs already driven at posedge+1; check mid-cycle, update scoreboard, advance.
    task automatic b_tick();
        logic        acc, xfer;
        logic [64:0] m;
        beat_t       e;
        #1;
        chk("b_in_ready", 64'(b_ready), 64'(!(q.size() == 3 && !b_oready)));
        if (b_ovalid) begin
            if (q.size() == 0) begin
                chk("b_spurious_beat", 64'(b_ovalid), 64'(0));
            end else begin
                chk("b_imm", b_imm, q[0].imm);
                chk("b_ill", 64'(b_ill), 64'(q[0].ill));
                chk("b_tag", 64'(b_otag), 64'(q[0].tag));
            end
        end
        if (stall_prev) begin
            chk("b_hold_valid", 64'(b_ovalid), 64'(1));
            chk("b_hold_imm", b_imm, prev_imm);
            chk("b_hold_ill", 64'(b_ill), 64'(prev_ill));
            chk("b_hold_tag", 64'(b_otag), 64'(prev_tag));
        end
        acc  = b_valid && b_ready;
        xfer = b_ovalid && b_oready;
        stall_prev = b_ovalid && !b_oready && !b_flush;
        prev_imm = b_imm;
        prev_ill = b_ill;
        prev_tag = b_otag;
        if (xfer && q.size() > 0) void'(q.pop_front());
        if (b_flush) begin
            q.delete();
        end else if (acc) begin
            m     = ref_model({b_inst, 7'b0}, b_src);
            e.imm = m[63:0];
            e.ill = m[64];
            e.tag = b_tag;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [64:0] m;
        int          i, tagcnt;
        logic        seen;

        tbl[0]  = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        tbl[1]  = '{32'hFE20AE23, 3'd1, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[2]  = '{32'hFE000CE3, 3'd5, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        tbl[3]  = '{32'h123450B7, 3'd6, 64'h0000000012345000, 1'b0};
        tbl[4]  = '{32'hFFDFF06F, 3'd2, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        tbl[5]  = '{32'h80000037, 3'd6, 64'hFFFFFFFF80000000, 1'b0};
        tbl[6]  = '{32'h000F8073, 3'd4, 64'h000000000000001F, 1'b0};
        tbl[7]  = '{32'hFFFFFFFF, 3'd4, 64'h000000000000001F, 1'b0};
        tbl[8]  = '{32'hFFFFFFFF, 3'd3, 64'h0000000000000000, 1'b1};
        tbl[9]  = '{32'hFFFFFFFF, 3'd7, 64'h0000000000000000, 1'b1};
        tbl[10] = '{32'h7FF00093, 3'd0, 64'h00000000000007FF, 1'b0};

        reset = 1'b1;
        a_valid = 0; a_flush = 0; a_oready = 1; a_inst = '0; a_src = '0; a_tag = '0;
        b_valid = 0; b_flush = 0; b_oready = 1; b_inst = '0; b_src = '0; b_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_a1_valid", 64'(a1_valid), 64'(0));
        chk("rst_a1_imm", 64'(a1_imm), 64'(0));
        chk("rst_a1_ready", 64'(a1_ready), 64'(1));
        chk("rst_b_valid", 64'(b_ovalid), 64'(0));
        chk("rst_b_imm", b_imm, 64'(0));
        chk("rst_b_ill", 64'(b_ill), 64'(0));
        chk("rst_b_tag", 64'(b_otag), 64'(0));
        chk("rst_b_ready", 64'(b_ready), 64'(1));
        @(posedge clk);
        #1;

        // Back-to-back table stream: exact latency of 1, 2 and 3 cycles.
        for (int j = 0; j < NV + 3; j++) begin
            a_valid = (j < NV);
            if (j < NV) begin
                a_inst = tbl[j].inst[31:7];
                a_src  = tbl[j].src;
            end
            a_tag = 8'(j);
            b_valid = a_valid; b_inst = a_inst; b_src = a_src; b_tag = a_tag;
            #1;
            chk("a1_in_ready", 64'(a1_ready), 64'(1));
            chk("a2_in_ready", 64'(a2_ready), 64'(1));
            i = j - 1;
            chk("a1_valid", 64'(a1_valid), 64'(i >= 0 && i < NV));
            if (i >= 0 && i < NV) begin
                chk("a1_imm", 64'(a1_imm), 64'(tbl[i].imm[31:0]));
                chk("a1_ill", 64'(a1_ill), 64'(tbl[i].ill));
                chk("a1_tag", 64'(a1_tag), 64'(i));
            end
            i = j - 2;
            chk("a2_valid", 64'(a2_valid), 64'(i >= 0 && i < NV));
            if (i >= 0 && i < NV) begin
                chk("a2_imm", 64'(a2_imm), 64'(tbl[i].imm[31:0]));
                chk("a2_ill", 64'(a2_ill), 64'(tbl[i].ill));
                chk("a2_tag", 64'(a2_tag), 64'(i));
            end
            i = j - 3;
            chk("b_lat_valid", 64'(b_ovalid), 64'(i >= 0 && i < NV));
            if (i >= 0 && i < NV) begin
                chk("b_lat_imm", b_imm, tbl[i].imm);
                chk("b_lat_ill", 64'(b_ill), 64'(tbl[i].ill));
            end
            @(posedge clk);
            #1;
        end
        a_valid = 0;

        // Random traffic with random backpressure against the scoreboard.
        tagcnt = 0;
        for (int c = 0; c < 400; c++) begin
            b_valid  = ($urandom_range(0, 3) != 0);
            b_inst   = 25'($urandom);
            b_src    = 3'($urandom_range(0, 7));
            b_tag    = 8'(tagcnt);
            b_oready = ($urandom_range(0, 1) == 1);
            if (b_valid && (q.size() < 3 || b_oready)) tagcnt++;
            b_tick();
        end
        b_valid = 0; b_oready = 1;
        for (int c = 0; c < 10 && q.size() > 0; c++) b_tick();
        chk("b_drain_empty", 64'(q.size()), 64'(0));

        // Flush with a full pipe and an incoming beat in the same cycle.
        b_oready = 0;
        for (int t = 1; t <= 3; t++) begin
            b_valid = 1; b_inst = 25'(32'hFFF00093 >> 7); b_src = 3'd0; b_tag = 8'(t);
            b_tick();
        end
        b_valid = 1; b_tag = 8'h55; b_flush = 1;
        b_tick();
        b_flush = 0; b_valid = 0; b_oready = 1;
        #1;
        chk("flush_out_valid", 64'(b_ovalid), 64'(0));
        chk("flush_in_ready", 64'(b_ready), 64'(1));
        b_valid = 1; b_tag = 8'hAA; b_inst = 25'(32'h123450B7 >> 7); b_src = 3'd6;
        b_tick();
        b_valid = 0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            #1;
            if (b_ovalid) begin
                seen = 1'b1;
                chk("flush_first_tag", 64'(b_otag), 64'(8'hAA));
                chk("flush_first_imm", b_imm, 64'h0000000012345000);
            end
            #1;
            b_tick();
        end
        if (!seen) chk("flush_first_seen", 64'(seen), 64'(1));

        // Reset mid-stream.
        b_oready = 0;
        for (int t = 0; t < 2; t++) begin
            b_valid = 1; b_inst = 25'(32'hFFF00093 >> 7); b_src = 3'd0; b_tag = 8'h77;
            b_tick();
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0; b_valid = 0;
        q.delete();
        stall_prev = 1'b0;
        #1;
        chk("mrst_valid", 64'(b_ovalid), 64'(0));
        chk("mrst_imm", b_imm, 64'(0));
        chk("mrst_ill", 64'(b_ill), 64'(0));
        chk("mrst_tag", 64'(b_otag), 64'(0));
        chk("mrst_ready", 64'(b_ready), 64'(1));
        chk("mrst_a2_imm", 64'(a2_imm), 64'(0));
        chk("mrst_a2_tag", 64'(a2_tag), 64'(0));
        b_oready = 1;
        #1;
        for (int c = 0; c < 6; c++) b_tick();

        m = ref_model(32'h80000037, 3'd6);
        if (m[63:0] !== 64'hFFFFFFFF80000000)
            $display("note: reference model disagrees with table on U-type");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
